// File: rtl/Purple_Jade_pkg.sv
// Shared types for the writeback path: CDB broadcast, ROB writeback and
// register-file writeback packets, plus the core-wide sizing constants.
package Purple_Jade_pkg;

   localparam int ROB_ENTRY    = 16;
   localparam int NUM_PHYS_REG = 64;
   localparam int WORD_SIZE_P  = 32;
   localparam int WB_PORTS     = 3;   // fu_mult, ALU, load unit

   localparam int ROB_IDX_W  = $clog2(ROB_ENTRY);
   localparam int PREG_IDX_W = $clog2(NUM_PHYS_REG);

   typedef struct packed {
      logic                   valid;
      logic [ROB_IDX_W-1:0]   rob_dest;
      logic [PREG_IDX_W-1:0]  dest;
      logic [WORD_SIZE_P-1:0] result;
   } cdb_t;

   typedef struct packed {
      cdb_t cdb;
      logic exception;
      logic br_mispredict;
   } rob_wb_t;

   typedef struct packed {
      cdb_t cdb;
      logic w_v;
   } reg_wb_t;

   localparam int ROB_WB_WIDTH = $bits(rob_wb_t);
   localparam int REG_WB_WIDTH = $bits(reg_wb_t);

   // Round-robin successor of a port index, wrapping at num_ports.
   function automatic int rr_next(input int idx, input int num_ports);
      return (idx + 1 >= num_ports) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of rob_wb_t packets holding writebacks that lost arbitration.
// Flush empties it in one edge; a push into a full FIFO is accepted only when
// the head is popped on the same edge.
module wb_fifo
   import Purple_Jade_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         flush_i,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  rob_wb_t                      data_i,
   output rob_wb_t                      data_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         empty_o,
   output logic                         full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   rob_wb_t         mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [CW-1:0]   count_q;
   logic            pop_ok;
   logic            push_ok;

   // Qualify requests: flush wins, pops need data, pushes need room.
   always_comb begin
      pop_ok  = pop_i && !empty_o && !flush_i;
      push_ok = push_i && (!full_o || pop_ok) && !flush_i;
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr] <= data_i;
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign data_o  = mem[rd_ptr];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the functional-unit writeback streams onto the
// single registered CDB/ROB port.
//
// Handshake: an FU packet is offered when .cdb.valid is 1 and there is no
// ready back-pressure; every valid packet is either granted straight through
// (bypass, FIFO empty), queued in its port FIFO, or dropped with the sticky
// overflow flag set. The CDB output is a plain registered valid with no ready.
module wb_arbiter
   import Purple_Jade_pkg::*;
#(
   parameter int NUM_PORTS  = WB_PORTS,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                               clk_i,
   input  logic                                               reset_i,
   input  logic [NUM_PORTS-1:0][ROB_WB_WIDTH-1:0]             fu_rob_i,
   input  logic                                               mispredict_i,
   output logic [ROB_WB_WIDTH-1:0]                            cdb_rob_o,
   output logic [REG_WB_WIDTH-1:0]                            cdb_reg_o,
   output logic [NUM_PORTS-1:0][$clog2(FIFO_DEPTH+1)-1:0]     fifo_free_o,
   output logic                                               overflow_o
);

   localparam int FREE_W = $clog2(FIFO_DEPTH+1);
   localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   rob_wb_t               in_pkt [NUM_PORTS];
   rob_wb_t               head   [NUM_PORTS];
   rob_wb_t               cand   [NUM_PORTS];
   logic [FREE_W-1:0]     cnt    [NUM_PORTS];
   logic [NUM_PORTS-1:0]  in_v;
   logic [NUM_PORTS-1:0]  cand_v;
   logic [NUM_PORTS-1:0]  fifo_empty;
   logic [NUM_PORTS-1:0]  fifo_full;
   logic [NUM_PORTS-1:0]  sel;
   logic [NUM_PORTS-1:0]  bypass;
   logic [NUM_PORTS-1:0]  push;
   logic [NUM_PORTS-1:0]  pop;
   logic [NUM_PORTS-1:0]  drop;

   logic                  gnt_any;
   logic [PTR_W-1:0]      gnt_idx;
   logic [PTR_W-1:0]      gnt_next;
   rob_wb_t               gnt_pkt;

   logic [PTR_W-1:0]      rr_ptr;
   rob_wb_t               out_q;
   logic                  ovf_q;
   reg_wb_t               reg_wb;

   // Per-port FIFOs and unpacking of the flat input bus.
   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      assign in_pkt[g] = rob_wb_t'(fu_rob_i[g]);

      wb_fifo #(
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .flush_i (mispredict_i),
         .push_i  (push[g]),
         .pop_i   (pop[g]),
         .data_i  (in_pkt[g]),
         .data_o  (head[g]),
         .count_o (cnt[g]),
         .empty_o (fifo_empty[g]),
         .full_o  (fifo_full[g])
      );

      assign fifo_free_o[g] = FREE_W'(FIFO_DEPTH) - cnt[g];
   end

   // Candidate per port: queued head first, otherwise the live packet.
   always_comb begin
      in_v   = '0;
      cand_v = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         in_v[p]   = in_pkt[p].cdb.valid;
         cand_v[p] = !fifo_empty[p] || in_v[p];
         cand[p]   = fifo_empty[p] ? in_pkt[p] : head[p];
      end
   end

   // Round-robin search starting at rr_ptr; first candidate found wins.
   always_comb begin
      int idx;
      idx     = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      gnt_pkt = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!gnt_any && cand_v[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = PTR_W'(idx);
            gnt_pkt = cand[idx];
         end
      end
      gnt_next = PTR_W'(rr_next(int'(gnt_idx), NUM_PORTS));
   end

   // Per-port consequences of the grant: bypass, pop, push or drop.
   always_comb begin
      sel    = '0;
      bypass = '0;
      pop    = '0;
      push   = '0;
      drop   = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         sel[p]    = gnt_any && (gnt_idx == PTR_W'(p));
         bypass[p] = sel[p] && fifo_empty[p];
         pop[p]    = sel[p] && !fifo_empty[p] && !mispredict_i;
         push[p]   = in_v[p] && !bypass[p] && (!fifo_full[p] || pop[p]) && !mispredict_i;
         drop[p]   = in_v[p] && !bypass[p] && fifo_full[p] && !pop[p] && !mispredict_i;
      end
   end

   // CDB output register, round-robin pointer and sticky overflow flag.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         out_q  <= '0;
         rr_ptr <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (mispredict_i) begin
            out_q <= '0;
         end else if (gnt_any) begin
            out_q  <= gnt_pkt;
            rr_ptr <= gnt_next;
         end else begin
            out_q <= '0;
         end
         if (|drop) ovf_q <= 1'b1;
      end
   end

   // Register-file view of the same broadcast.
   always_comb begin
      reg_wb.cdb = out_q.cdb;
      reg_wb.w_v = out_q.cdb.valid;
   end

   assign cdb_rob_o  = out_q;
   assign cdb_reg_o  = reg_wb;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model, expected-packet
// scoreboard and a negedge monitor.
module tb_wb_arbiter;
   import Purple_Jade_pkg::*;

   localparam int NP    = WB_PORTS;
   localparam int DEPTH = 4;
   localparam int FW    = $clog2(DEPTH+1);

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic reset_i;
   logic [NP-1:0][ROB_WB_WIDTH-1:0] fu_rob_i;
   logic mispredict_i;
   logic [ROB_WB_WIDTH-1:0] cdb_rob_o;
   logic [REG_WB_WIDTH-1:0] cdb_reg_o;
   logic [NP-1:0][FW-1:0]   fifo_free_o;
   logic overflow_o;

   always #5 clk_i = ~clk_i;

   wb_arbiter #(
      .NUM_PORTS  (NP),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .fu_rob_i     (fu_rob_i),
      .mispredict_i (mispredict_i),
      .cdb_rob_o    (cdb_rob_o),
      .cdb_reg_o    (cdb_reg_o),
      .fifo_free_o  (fifo_free_o),
      .overflow_o   (overflow_o)
   );

   // ---------------- bookkeeping ----------------
   int n_vec = 0;
   int n_err = 0;
   int edge_n = 0;
   bit mon_en = 1'b0;
   int tag = 32'h100;

   logic [ROB_WB_WIDTH-1:0] exp_q[$];
   int                      exp_t_q[$];

   // reference model state
   logic [ROB_WB_WIDTH-1:0] mq [NP][$];
   int m_rr;
   bit m_ovf;
   int nxt_free [NP];
   int cur_free [NP];
   bit nxt_ovf;
   bit cur_ovf;

   rob_wb_t         in_pkt [NP];
   logic [NP-1:0]   in_v;

   always @(posedge clk_i) edge_n++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic rob_wb_t mk_pkt(input int rd, input int d, input logic [31:0] res, input bit v);
      rob_wb_t p;
      p.cdb.valid     = v;
      p.cdb.rob_dest  = ROB_IDX_W'(rd);
      p.cdb.dest      = PREG_IDX_W'(d);
      p.cdb.result    = res;
      p.exception     = 1'($urandom_range(0, 1));
      p.br_mispredict = 1'($urandom_range(0, 1));
      return p;
   endfunction

   task automatic model_clear();
      for (int p = 0; p < NP; p++) begin
         mq[p].delete();
         nxt_free[p] = DEPTH;
         cur_free[p] = DEPTH;
      end
      exp_q.delete();
      exp_t_q.delete();
      m_rr    = 0;
      m_ovf   = 1'b0;
      nxt_ovf = 1'b0;
      cur_ovf = 1'b0;
   endtask

   // One edge of the arbiter as described by its rules, using queues.
   task automatic model_step();
      int g;
      int bp;
      bit found;
      logic [ROB_WB_WIDTH-1:0] pkt;
      if (mispredict_i) begin
         for (int p = 0; p < NP; p++) mq[p].delete();
      end else begin
         found = 1'b0;
         g     = 0;
         bp    = -1;
         for (int i = 0; i < NP; i++) begin
            int p;
            p = (m_rr + i) % NP;
            if (!found && (mq[p].size() > 0 || in_v[p])) begin
               found = 1'b1;
               g     = p;
            end
         end
         if (found) begin
            if (mq[g].size() > 0) begin
               pkt = mq[g].pop_front();
            end else begin
               pkt = in_pkt[g];
               bp  = g;
            end
            exp_q.push_back(pkt);
            exp_t_q.push_back(edge_n + 1);
            m_rr = (g + 1) % NP;
         end
         for (int p = 0; p < NP; p++) begin
            if (in_v[p] && p != bp) begin
               if (mq[p].size() < DEPTH) mq[p].push_back(in_pkt[p]);
               else                      m_ovf = 1'b1;
            end
         end
      end
      for (int p = 0; p < NP; p++) nxt_free[p] = DEPTH - mq[p].size();
      nxt_ovf = m_ovf;
   endtask

   // ---------------- driver ----------------
   // Drives one cycle of inputs just after a rising edge. With use_dir the
   // caller has already filled in_pkt.
   task automatic step(input logic [NP-1:0] v, input bit mp, input bit use_dir);
      @(posedge clk_i);
      #1;
      for (int p = 0; p < NP; p++) cur_free[p] = nxt_free[p];
      cur_ovf = nxt_ovf;
      for (int p = 0; p < NP; p++) begin
         if (!use_dir) begin
            if (v[p]) begin
               in_pkt[p] = mk_pkt($urandom_range(0, ROB_ENTRY-1), $urandom_range(0, NUM_PHYS_REG-1), tag, 1'b1);
               tag++;
            end else begin
               in_pkt[p] = mk_pkt($urandom_range(0, ROB_ENTRY-1), $urandom_range(0, NUM_PHYS_REG-1), $urandom, 1'b0);
            end
         end
         in_pkt[p].cdb.valid = v[p];
         fu_rob_i[p] = in_pkt[p];
      end
      in_v         = v;
      mispredict_i = mp;
      model_step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0);
   endtask

   // Reset asserted between edges; outputs must clear with no clock edge.
   task automatic reset_mid();
      @(posedge clk_i);
      #2;
      reset_i = 1'b1;
      #1;
      chk("rst_cdb_rob", 64'(cdb_rob_o), 64'd0);
      chk("rst_cdb_reg", 64'(cdb_reg_o), 64'd0);
      for (int p = 0; p < NP; p++) chk("rst_fifo_free", 64'(fifo_free_o[p]), 64'(DEPTH));
      chk("rst_overflow", 64'(overflow_o), 64'd0);
      model_clear();
      in_v         = '0;
      fu_rob_i     = '0;
      mispredict_i = 1'b0;
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk_i) begin
      rob_wb_t a;
      reg_wb_t r;
      logic [ROB_WB_WIDTH-1:0] e;
      rob_wb_t es;
      int t;
      bit due;
      if (mon_en && !reset_i) begin
         a = cdb_rob_o;
         r = cdb_reg_o;
         if (a.cdb.valid) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL cdb_unexpected: got %0h expected no packet at t=%0t", a, $time);
            end else begin
               e  = exp_q.pop_front();
               t  = exp_t_q.pop_front();
               es = e;
               chk("cdb_rob", 64'(a), 64'(e));
               chk("cdb_edge", 64'(edge_n), 64'(t));
               chk("cdb_reg", 64'(r), 64'({es.cdb, 1'b1}));
            end
         end else begin
            due = (exp_q.size() > 0) && (exp_t_q[0] <= edge_n);
            chk("cdb_missing", 64'(due), 64'd0);
            if (due) begin
               void'(exp_q.pop_front());
               void'(exp_t_q.pop_front());
            end
            chk("cdb_reg_idle", 64'(r.w_v), 64'd0);
         end
         for (int p = 0; p < NP; p++) chk("fifo_free", 64'(fifo_free_o[p]), 64'(cur_free[p]));
         chk("overflow", 64'(overflow_o), 64'(cur_ovf));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset_i      = 1'b1;
      mispredict_i = 1'b0;
      fu_rob_i     = '0;
      in_v         = '0;
      for (int p = 0; p < NP; p++) in_pkt[p] = '0;
      model_clear();
      #12;
      chk("init_cdb_rob", 64'(cdb_rob_o), 64'd0);
      chk("init_cdb_reg", 64'(cdb_reg_o), 64'd0);
      for (int p = 0; p < NP; p++) chk("init_fifo_free", 64'(fifo_free_o[p]), 64'(DEPTH));
      chk("init_overflow", 64'(overflow_o), 64'd0);
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      mon_en  = 1'b1;

      // single bypass on port 0
      in_pkt[0] = mk_pkt(5, 12, 32'h1234, 1'b1);
      in_pkt[1] = mk_pkt(0, 0, 32'h0, 1'b0);
      in_pkt[2] = mk_pkt(0, 0, 32'h0, 1'b0);
      step(3'b001, 1'b0, 1'b1);
      idle(2);

      // port 2 alone brings the pointer back to 0, then a 3-way collision
      step(3'b100, 1'b0, 1'b0);
      idle(1);
      in_pkt[0] = mk_pkt(1, 1, 32'hA, 1'b1);
      in_pkt[1] = mk_pkt(2, 2, 32'hB, 1'b1);
      in_pkt[2] = mk_pkt(3, 3, 32'hC, 1'b1);
      step(3'b111, 1'b0, 1'b1);
      idle(4);

      // ports 1 and 2 back up, exercising the rotating grant
      step(3'b110, 1'b0, 1'b0);
      step(3'b110, 1'b0, 1'b0);
      step(3'b110, 1'b0, 1'b0);
      idle(6);

      // sustained full load: FIFOs fill and packets get dropped
      for (int i = 0; i < 8; i++) step(3'b111, 1'b0, 1'b0);
      idle(12);
      chk("overflow_sticky", 64'(overflow_o), 64'd1);

      // mispredict with entries queued and a live input
      step(3'b111, 1'b0, 1'b0);
      step(3'b111, 1'b0, 1'b0);
      step(3'b010, 1'b1, 1'b0);
      idle(3);

      // reset mid-operation with port 1 backed up
      step(3'b111, 1'b0, 1'b0);
      step(3'b111, 1'b0, 1'b0);
      reset_mid();

      // randomized traffic with occasional flushes and one reset
      for (int i = 0; i < 1500; i++) begin
         logic [NP-1:0] v;
         bit mp;
         v  = NP'($urandom_range(0, (1 << NP) - 1));
         if ($urandom_range(0, 3) == 0) v = '0;
         mp = ($urandom_range(0, 39) == 0);
         step(v, mp, 1'b0);
         if (i == 700) reset_mid();
      end
      idle(15);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Hard stop if the run ever stalls.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
